// File: rtl/rr_arb_2a1_pkg.sv
// rr_arb_2a1_pkg: state encoding (state doubles as one-hot grant) and default sizing
package rr_arb_2a1_pkg;
    typedef enum logic [1:0] {IDLE = 2'b00, G0 = 2'b01, G1 = 2'b10} state_t;
    localparam int MAX_BURST_DEF = 4;
    localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/rr_arb_2a1_burst_cnt.sv
// burst_cnt: beat counter with clear/enable and terminal count at MAX_BURST-1
module burst_cnt
    import rr_arb_2a1_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else if (i_clr) r_cnt <= '0;
        else if (i_en) r_cnt <= r_cnt + 1'b1;
    end
    assign o_tc = r_cnt == CNT_W'(MAX_BURST - 1);
endmodule

// File: rtl/rr_arb_2a1.sv
// rr_arb_2a1: two-requester round-robin arbiter with burst cap, drives 2:1 mux select
module rr_arb_2a1
    import rr_arb_2a1_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       ready,
    output logic [1:0] gnt,
    output logic       sel,
    output logic       fire,
    output logic       busy
);
    state_t r_state, w_nxt, w_go;
    logic r_ptr, r_sel, r_busy;
    logic w_ptr_nxt, w_i, w_own, w_oth, w_tc, w_clr;
    assign gnt   = r_state;
    assign sel   = r_sel;
    assign busy  = r_busy;
    assign fire  = |(gnt & req) & ready;
    assign w_i   = r_state == G1;
    assign w_own = req[w_i];
    assign w_oth = req[~w_i];
    assign w_go  = w_i ? G0 : G1;
    burst_cnt #(.MAX_BURST(MAX_BURST), .CNT_W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .i_clr(w_clr),
        .i_en (fire),
        .o_tc (w_tc)
    );
    // Release takes precedence over expiry; both hand the pointer to the other source.
    always_comb begin
        w_nxt = r_state;
        w_ptr_nxt = r_ptr;
        w_clr = 1'b0;
        if (r_state == IDLE) begin
            w_clr = 1'b1;
            w_nxt = req == 2'b11 ? (r_ptr ? G1 : G0) : req == 2'b01 ? G0 : req == 2'b10 ? G1 : IDLE;
        end else if (!w_own) begin
            w_clr = 1'b1;
            w_nxt = w_oth ? w_go : IDLE;
            w_ptr_nxt = ~w_i;
        end else if (fire && w_tc) begin
            w_clr = 1'b1;
            w_nxt = w_oth ? w_go : r_state;
            w_ptr_nxt = w_oth ? ~w_i : r_ptr;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr <= 1'b0;
            r_sel <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_ptr <= w_ptr_nxt;
            r_sel <= w_nxt == IDLE ? r_sel : w_nxt == G1;
            r_busy <= w_nxt != IDLE;
        end
    end
endmodule

// File: tb/tb_rr_arb_2a1.sv
// tb_rr_arb_2a1: directed checks of rr_arb_2a1 with MAX_BURST=4 and MAX_BURST=1 instances
module tb_rr_arb_2a1;
    logic clk = 1'b0;
    logic rst, ready, ready1;
    logic [1:0] req, req1, gnt, gnt1;
    logic sel, fire, busy, sel1, fire1, busy1;
    int total = 0;
    int bad = 0;

    rr_arb_2a1 #(.MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .ready(ready),
        .gnt(gnt), .sel(sel), .fire(fire), .busy(busy)
    );
    rr_arb_2a1 #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .ready(ready1),
        .gnt(gnt1), .sel(sel1), .fire(fire1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst) assert ($onehot0(gnt) && $onehot0(gnt1)) else $error("gnt not one-hot: %b %b", gnt, gnt1);

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; ready = 1'b0; req1 = 2'b00; ready1 = 1'b1;
        repeat (2) step;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_sel", sel, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fire", fire, 1'b0);
        chk("rst_gnt1", gnt1, 2'b00);
        rst = 1'b0; req = 2'b01; ready = 1'b1;
        step;
        for (int i = 0; i < 10; i++) begin
            chk("single_gnt", gnt, 2'b01);
            chk("single_sel", sel, 1'b0);
            chk("single_fire", fire, 1'b1);
            chk("single_busy", busy, 1'b1);
            step;
        end
        req = 2'b00;
        step;
        chk("idle_gnt", gnt, 2'b00);
        chk("idle_busy", busy, 1'b0);
        chk("idle_sel", sel, 1'b0);
        req = 2'b11;
        step;
        chk("pre_rst_gnt", gnt, 2'b10);
        chk("pre_rst_sel", sel, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", gnt, 2'b00);
        chk("arst_sel", sel, 1'b0);
        chk("arst_busy", busy, 1'b0);
        #2 rst = 1'b0;
        step;
        for (int k = 0; k < 15; k++) begin
            chk("rr_gnt", gnt, ((k / 4) % 2) != 0 ? 2'b10 : 2'b01);
            chk("rr_sel", sel, ((k / 4) % 2) != 0 ? 1'b1 : 1'b0);
            chk("rr_fire", fire, 1'b1);
            if (k < 14) step;
        end
        ready = 1'b0;
        #1 chk("stall_fire0", fire, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step;
            chk("stall_gnt", gnt, 2'b10);
            chk("stall_fire", fire, 1'b0);
        end
        ready = 1'b1;
        #1 chk("resume_fire", fire, 1'b1);
        step;
        chk("resume_last_beat", gnt, 2'b10);
        step;
        chk("resume_switch", gnt, 2'b01);
        chk("resume_sel", sel, 1'b0);
        req = 2'b10;
        #1 chk("drop_fire", fire, 1'b0);
        step;
        chk("handover_gnt", gnt, 2'b10);
        chk("handover_busy", busy, 1'b1);
        req = 2'b00;
        step;
        chk("release_gnt", gnt, 2'b00);
        chk("release_sel_hold", sel, 1'b1);
        chk("release_busy", busy, 1'b0);
        req = 2'b11;
        step;
        chk("favoured_gnt", gnt, 2'b01);
        req1 = 2'b11;
        step;
        for (int k = 0; k < 8; k++) begin
            chk("mb1_gnt", gnt1, (k % 2) != 0 ? 2'b10 : 2'b01);
            chk("mb1_fire", fire1, 1'b1);
            step;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
